// File: rtl/rgb_led_pkg.sv
// Shared constants and index helper for the RGB LED button controller.
package rgb_led_pkg;

    // Colour slot of a button within its LED triple
    localparam int COLOR_R = 0;
    localparam int COLOR_G = 1;
    localparam int COLOR_B = 2;

    // Colour-bit update behaviour
    localparam int MODE_TOGGLE    = 0;
    localparam int MODE_MOMENTARY = 1;

    // Button index owning colour 'colour' of LED 'led'
    function automatic int btn_idx(input int led, input int colour);
        return 3 * led + colour;
    endfunction

endpackage

// File: rtl/rgb_led_button_ctrl_debounce.sv
// Per-button conditioning: 2-flop synchroniser, stability counter and
// rising-edge detect. 'level' is the accepted (debounced) button level;
// 'rise' is combinational and high for the one cycle after 'level' rises,
// so the parent can register it on the same edge it updates colour bits.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_lvl;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_lvl  <= sync_meta;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_lvl == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_lvl;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Remember last accepted level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/rgb_led_button_ctrl.sv
// Button-to-RGB-LED controller: one debounced button per colour bit,
// toggle or momentary colour update, shared PWM brightness on all LEDs.
module rgb_led_button_ctrl
    import rgb_led_pkg::*;
#(
    parameter int NUM_LED         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_BITS        = 8,
    parameter int MODE            = MODE_TOGGLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3*NUM_LED-1:0]  btn,
    input  logic [PWM_BITS-1:0]   duty,
    input  logic                  clr_all,
    output logic [NUM_LED-1:0]    led_r,
    output logic [NUM_LED-1:0]    led_g,
    output logic [NUM_LED-1:0]    led_b,
    output logic [3*NUM_LED-1:0]  color_state,
    output logic [3*NUM_LED-1:0]  press_pulse
);

    localparam int NUM_BTN = 3 * NUM_LED;

    logic [NUM_BTN-1:0]  level;
    logic [NUM_BTN-1:0]  rise;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [NUM_LED-1:0]  red_bits;
    logic [NUM_LED-1:0]  green_bits;
    logic [NUM_LED-1:0]  blue_bits;

    // One conditioning channel per button
    for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn[k]),
            .level (level[k]),
            .rise  (rise[k])
        );
    end

    // Regroup the flat colour register into per-colour LED planes
    for (genvar i = 0; i < NUM_LED; i++) begin : g_plane
        assign red_bits[i]   = color_state[btn_idx(i, COLOR_R)];
        assign green_bits[i] = color_state[btn_idx(i, COLOR_G)];
        assign blue_bits[i]  = color_state[btn_idx(i, COLOR_B)];
    end

    // Register debounced rising edges as one-cycle press pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse <= '0;
        end else begin
            press_pulse <= rise;
        end
    end

    // Colour bits: toggle on press (clear wins) or follow the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_state <= '0;
        end else if (MODE == MODE_TOGGLE) begin
            if (clr_all) begin
                color_state <= '0;
            end else begin
                color_state <= color_state ^ rise;
            end
        end else begin
            color_state <= level;
        end
    end

    // Free-running PWM counter, wraps naturally at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // All-ones duty forces the output fully on instead of 15/16-style
    assign pwm_on = (duty == '1) | (pwm_cnt < duty);

    // Gate colour bits with the shared PWM phase into the LED pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= '0;
            led_g <= '0;
            led_b <= '0;
        end else begin
            led_r <= red_bits   & {NUM_LED{pwm_on}};
            led_g <= green_bits & {NUM_LED{pwm_on}};
            led_b <= blue_bits  & {NUM_LED{pwm_on}};
        end
    end

endmodule

// File: tb/tb_rgb_led_button_ctrl.sv
// Bench for rgb_led_button_ctrl: a toggle-mode and a momentary-mode instance,
// directed stimulus, press-pulse scoreboard plus direct level checks.
module tb_rgb_led_button_ctrl;

    typedef struct packed {
        logic [11:0] pulse;
        logic [11:0] color;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] btn_a, btn_b;
    logic [3:0]  duty_a, duty_b;
    logic        clr_a, clr_b;
    logic [3:0]  led_r_a, led_g_a, led_b_a;
    logic [3:0]  led_r_b, led_g_b, led_b_b;
    logic [11:0] cs_a, cs_b;
    logic [11:0] pp_a, pp_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rgb_led_button_ctrl #(
        .NUM_LED(4), .DEBOUNCE_CYCLES(4), .PWM_BITS(4), .MODE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn(btn_a), .duty(duty_a), .clr_all(clr_a),
        .led_r(led_r_a), .led_g(led_g_a), .led_b(led_b_a),
        .color_state(cs_a), .press_pulse(pp_a)
    );

    rgb_led_button_ctrl #(
        .NUM_LED(4), .DEBOUNCE_CYCLES(4), .PWM_BITS(4), .MODE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn(btn_b), .duty(duty_b), .clr_all(clr_b),
        .led_r(led_r_b), .led_g(led_g_b), .led_b(led_b_b),
        .color_state(cs_b), .press_pulse(pp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_red0(output int n);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_r_a[0]) n++;
        end
    endtask

    // Scoreboard monitor, toggle instance
    always @(negedge clk) begin
        if (pp_a !== 12'h000) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL pulse_a_unexpected: got pulse %h required none", pp_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (pp_a !== e.pulse || cs_a !== e.color) begin
                    n_err++;
                    $display("FAIL pulse_a: got pulse %h color %h required pulse %h color %h",
                             pp_a, cs_a, e.pulse, e.color);
                end
            end
        end
    end

    // Scoreboard monitor, momentary instance
    always @(negedge clk) begin
        if (pp_b !== 12'h000) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL pulse_b_unexpected: got pulse %h required none", pp_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (pp_b !== e.pulse || cs_b !== e.color) begin
                    n_err++;
                    $display("FAIL pulse_b: got pulse %h color %h required pulse %h color %h",
                             pp_b, cs_b, e.pulse, e.color);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100000");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        btn_a  = '0;  btn_b  = '0;
        duty_a = 4'hF; duty_b = 4'hF;
        clr_a  = 1'b0; clr_b = 1'b0;
        tick(3);
        chk("reset_outputs_a", {cs_a, pp_a, led_r_a, led_g_a, led_b_a}, 32'h0);
        chk("reset_outputs_b", {cs_b, pp_b, led_r_b, led_g_b, led_b_b}, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Toggle: press btn[4] -> pulse at edge 7, led_g[1] at edge 8
        qa.push_back('{pulse: 12'h010, color: 12'h010});
        btn_a[4] = 1'b1;
        tick(6);
        chk("toggle_pulse_edge6", pp_a, 12'h000);
        tick(1);
        chk("toggle_pulse_edge7", pp_a, 12'h010);
        chk("toggle_led_g_edge7", led_g_a, 4'b0000);
        tick(1);
        chk("toggle_led_g_edge8", led_g_a, 4'b0010);
        tick(2);
        btn_a[4] = 1'b0;
        tick(12);
        chk("toggle_release_keeps", cs_a, 12'h010);
        qa.push_back('{pulse: 12'h010, color: 12'h000});
        btn_a[4] = 1'b1;
        tick(10);
        btn_a[4] = 1'b0;
        tick(12);
        chk("toggle_second_press_led", led_g_a, 4'b0000);
        chk("toggle_second_press_cs", cs_a, 12'h000);

        // Glitch: 3 cycles rejected, 4 cycles accepted
        btn_a[0] = 1'b1;
        tick(3);
        btn_a[0] = 1'b0;
        tick(12);
        chk("glitch_3_rejected", cs_a, 12'h000);
        qa.push_back('{pulse: 12'h001, color: 12'h001});
        btn_a[0] = 1'b1;
        tick(4);
        btn_a[0] = 1'b0;
        tick(12);
        chk("glitch_4_accepted", cs_a, 12'h001);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        chk("clr_all_clears", cs_a, 12'h000);

        // Multi-press: all 12 buttons at once
        qa.push_back('{pulse: 12'hFFF, color: 12'hFFF});
        btn_a = 12'hFFF;
        tick(10);
        btn_a = 12'h000;
        tick(12);
        chk("multi_cs", cs_a, 12'hFFF);
        chk("multi_leds", {led_r_a, led_g_a, led_b_a}, 12'hFFF);

        // Reset mid-run with LEDs lit
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", {cs_a, pp_a, led_r_a, led_g_a, led_b_a}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("after_release_a", {cs_a, pp_a, led_r_a, led_g_a, led_b_a}, 32'h0);

        // Multi-press with clr_all on the pulse edge: clear wins
        btn_a = 12'hFFF;
        tick(6);
        clr_a = 1'b1;
        qa.push_back('{pulse: 12'hFFF, color: 12'h000});
        tick(1);
        clr_a = 1'b0;
        chk("clr_priority_cs", cs_a, 12'h000);
        tick(3);
        btn_a = 12'h000;
        tick(12);

        // PWM on led_r[0]
        qa.push_back('{pulse: 12'h001, color: 12'h001});
        btn_a[0] = 1'b1;
        tick(10);
        btn_a[0] = 1'b0;
        tick(12);
        duty_a = 4'd5;
        tick(2);
        count_red0(n);
        chk("pwm_duty5", n, 5);
        chk("pwm_other_colours", {led_g_a, led_b_a, led_r_a[3:1]}, 11'h0);
        duty_a = 4'd0;
        tick(2);
        count_red0(n);
        chk("pwm_duty0", n, 0);
        duty_a = 4'hF;
        tick(2);
        count_red0(n);
        chk("pwm_dutyF", n, 16);

        // Momentary mode: btn[11] drives led_b[3] while held
        qb.push_back('{pulse: 12'h800, color: 12'h800});
        btn_b[11] = 1'b1;
        tick(7);
        chk("mom_led_edge7", led_b_b, 4'b0000);
        tick(1);
        chk("mom_led_edge8", led_b_b, 4'b1000);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        chk("mom_clr_ignored", cs_b, 12'h800);
        tick(3);
        chk("mom_led_held", led_b_b, 4'b1000);
        btn_b[11] = 1'b0;
        tick(7);
        chk("mom_release_edge7", led_b_b, 4'b1000);
        tick(1);
        chk("mom_release_edge8", led_b_b, 4'b0000);
        chk("mom_release_cs", cs_b, 12'h000);
        tick(4);

        chk("scoreboard_a_drained", qa.size(), 0);
        chk("scoreboard_b_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
